// File: rtl/adpll_ctrl_pkg.sv
// Shared state encoding and default loop-filter constants for the ADPLL lock controller.
package adpll_ctrl_pkg;

  // State codes are visible on state_o, so the encoding is fixed.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSettle  = 3'd1,
    StAcquire = 3'd2,
    StTrack   = 3'd3,
    StLocked  = 3'd4,
    StFault   = 3'd5
  } adpll_state_e;

  localparam logic [2:0] KpAcqDefault = 3'b100;
  localparam logic [3:0] KiAcqDefault = 4'b0100;
  localparam logic [2:0] KpTrkDefault = 3'b010;
  localparam logic [3:0] KiTrkDefault = 4'b0001;

  localparam int unsigned LockThreshDefault = 4;

endpackage

// File: rtl/consec_window_cnt.sv
// Consecutive in-window / out-of-window sample counters with saturation and clear.
module consec_window_cnt #(
  parameter int unsigned InMax  = 16,
  parameter int unsigned OutMax = 4,
  parameter int unsigned InW    = $clog2(InMax + 1),
  parameter int unsigned OutW   = $clog2(OutMax + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  input  logic            in_win_i,
  input  logic            clr_i,
  // Counts after the current sample, before any clear; lets the FSM act on the same edge.
  output logic [InW-1:0]  in_nxt_o,
  output logic [OutW-1:0] out_nxt_o
);

  logic [InW-1:0]  in_cnt_q, in_cnt_d;
  logic [OutW-1:0] out_cnt_q, out_cnt_d;

  // Update counts on a valid sample; a clear wins over any update.
  always_comb begin
    in_nxt_o  = in_cnt_q;
    out_nxt_o = out_cnt_q;
    if (valid_i) begin
      if (in_win_i) begin
        out_nxt_o = '0;
        if (in_cnt_q != InW'(InMax)) in_nxt_o = in_cnt_q + 1'b1;
      end else begin
        in_nxt_o = '0;
        if (out_cnt_q != OutW'(OutMax)) out_nxt_o = out_cnt_q + 1'b1;
      end
    end
    in_cnt_d  = clr_i ? '0 : in_nxt_o;
    out_cnt_d = clr_i ? '0 : out_nxt_o;
  end

  // Count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

endmodule

// File: rtl/adpll_lock_ctrl.sv
// ADPLL lock controller: sequences settle, acquisition, tracking and lock, selecting loop gains.
module adpll_lock_ctrl
  import adpll_ctrl_pkg::*;
#(
  parameter int unsigned         ERROR_WIDTH   = 8,
  parameter int unsigned         KP_WIDTH      = 3,
  parameter int unsigned         KI_WIDTH      = 4,
  parameter logic [KP_WIDTH-1:0] KP_ACQ        = KpAcqDefault,
  parameter logic [KI_WIDTH-1:0] KI_ACQ        = KiAcqDefault,
  parameter logic [KP_WIDTH-1:0] KP_TRK        = KpTrkDefault,
  parameter logic [KI_WIDTH-1:0] KI_TRK        = KiTrkDefault,
  parameter int unsigned         LOCK_THRESH   = LockThreshDefault,
  parameter int unsigned         ACQ_COUNT     = 8,
  parameter int unsigned         LOCK_COUNT    = 16,
  parameter int unsigned         UNLOCK_COUNT  = 4,
  parameter int unsigned         SETTLE_CYCLES = 256,
  parameter int unsigned         TIMEOUT       = 1024
) (
  input  logic                          fpga_clk_i,
  input  logic                          reset_i,
  input  logic                          start_i,
  input  logic                          error_valid_i,
  input  logic signed [ERROR_WIDTH-1:0] error_i,
  output logic                          enable_o,
  output logic        [KP_WIDTH-1:0]    kp_o,
  output logic        [KI_WIDTH-1:0]    ki_o,
  output logic                          locked_o,
  output logic                          fault_o,
  output logic        [2:0]             state_o
);

  localparam int unsigned InMax = (ACQ_COUNT > LOCK_COUNT) ? ACQ_COUNT : LOCK_COUNT;
  localparam int unsigned InW   = $clog2(InMax + 1);
  localparam int unsigned OutW  = $clog2(UNLOCK_COUNT + 1);
  localparam int unsigned SetW  = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned SmpW  = $clog2(TIMEOUT + 1);

  adpll_state_e          state_q, state_d;
  logic [SetW-1:0]       settle_q, settle_d;
  logic [SmpW-1:0]       samp_q, samp_d, samp_inc;
  logic                  enable_q, enable_d, locked_q, locked_d, fault_q, fault_d;
  logic [KP_WIDTH-1:0]   kp_q, kp_d;
  logic [KI_WIDTH-1:0]   ki_q, ki_d;
  logic [ERROR_WIDTH:0]  err_ext, err_abs;
  logic                  in_win, sample, clr;
  logic [InW-1:0]        in_nxt;
  logic [OutW-1:0]       out_nxt;

  assign samp_inc = samp_q + 1'b1;

  // Magnitude in one extra bit so the most negative error maps to a positive out-of-window value.
  always_comb begin
    err_ext = {error_i[ERROR_WIDTH-1], error_i};
    err_abs = err_ext[ERROR_WIDTH] ? (~err_ext + 1'b1) : err_ext;
    in_win  = (err_abs <= (ERROR_WIDTH + 1)'(LOCK_THRESH));
    sample  = error_valid_i &&
              (state_q == StAcquire || state_q == StTrack || state_q == StLocked);
  end

  consec_window_cnt #(
    .InMax  (InMax),
    .OutMax (UNLOCK_COUNT)
  ) u_win_cnt (
    .clk_i     (fpga_clk_i),
    .rst_ni    (reset_i),
    .valid_i   (sample),
    .in_win_i  (in_win),
    .clr_i     (clr),
    .in_nxt_o  (in_nxt),
    .out_nxt_o (out_nxt)
  );

  // Next-state logic; start_i low overrides everything, unused codes fall back to idle.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    samp_d   = samp_q;
    if (!start_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: state_d = StSettle;
        StSettle: begin
          if (settle_q == SetW'(SETTLE_CYCLES - 1)) state_d = StAcquire;
          else settle_d = settle_q + 1'b1;
        end
        StAcquire: begin
          if (sample) begin
            samp_d = samp_inc;
            // Reaching acquisition count beats a timeout on the same sample.
            if (in_nxt == InW'(ACQ_COUNT)) state_d = StTrack;
            else if (samp_inc == SmpW'(TIMEOUT)) state_d = StFault;
          end
        end
        StTrack: begin
          if (sample) begin
            if (in_nxt == InW'(LOCK_COUNT)) state_d = StLocked;
            else if (out_nxt == OutW'(UNLOCK_COUNT)) state_d = StAcquire;
          end
        end
        StLocked: begin
          if (sample && out_nxt == OutW'(UNLOCK_COUNT)) state_d = StAcquire;
        end
        StFault: state_d = StFault;
        default: state_d = StIdle;
      endcase
    end
    clr = (state_d != state_q);
    if (clr) begin
      settle_d = '0;
      samp_d   = '0;
    end
  end

  // Moore outputs decoded from the next state so they register with the transition.
  always_comb begin
    enable_d = 1'b0;
    kp_d     = KP_ACQ;
    ki_d     = KI_ACQ;
    locked_d = 1'b0;
    fault_d  = 1'b0;
    case (state_d)
      StSettle, StAcquire: enable_d = 1'b1;
      StTrack: begin
        enable_d = 1'b1;
        kp_d     = KP_TRK;
        ki_d     = KI_TRK;
      end
      StLocked: begin
        enable_d = 1'b1;
        kp_d     = KP_TRK;
        ki_d     = KI_TRK;
        locked_d = 1'b1;
      end
      StFault: fault_d = 1'b1;
      default: enable_d = 1'b0;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge fpga_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= StIdle;
      settle_q <= '0;
      samp_q   <= '0;
      enable_q <= 1'b0;
      kp_q     <= KP_ACQ;
      ki_q     <= KI_ACQ;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      samp_q   <= samp_d;
      enable_q <= enable_d;
      kp_q     <= kp_d;
      ki_q     <= ki_d;
      locked_q <= locked_d;
      fault_q  <= fault_d;
    end
  end

  assign enable_o = enable_q;
  assign kp_o     = kp_q;
  assign ki_o     = ki_q;
  assign locked_o = locked_q;
  assign fault_o  = fault_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_adpll_lock_ctrl.sv
// Randomized bench for adpll_lock_ctrl against a cycle-level behavioural model.
module tb_adpll_lock_ctrl;

  logic              fpga_clk_i = 1'b0;
  logic              reset_i    = 1'b0;
  logic              start_i    = 1'b0;
  logic              error_valid_i = 1'b0;
  logic signed [7:0] error_i    = '0;
  logic              enable_o, locked_o, fault_o;
  logic [2:0]        kp_o, state_o;
  logic [3:0]        ki_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: state code, cycles spent in state, samples in state, consecutive run lengths.
  int m_state, m_dwell, m_samples, m_in_run, m_out_run;

  adpll_lock_ctrl dut (
    .fpga_clk_i    (fpga_clk_i),
    .reset_i       (reset_i),
    .start_i       (start_i),
    .error_valid_i (error_valid_i),
    .error_i       (error_i),
    .enable_o      (enable_o),
    .kp_o          (kp_o),
    .ki_o          (ki_o),
    .locked_o      (locked_o),
    .fault_o       (fault_o),
    .state_o       (state_o)
  );

  always #5 fpga_clk_i = ~fpga_clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [12:0] exp_outs(input int s);
    logic       trk;
    logic [2:0] code;
    trk  = (s == 3) || (s == 4);
    code = 3'(s);
    return {code, (s >= 1 && s <= 4), (trk ? 3'b010 : 3'b100), (trk ? 4'b0001 : 4'b0100),
            (s == 4), (s == 5)};
  endfunction

  function automatic logic [12:0] obs_outs();
    return {state_o, enable_o, kp_o, ki_o, locked_o, fault_o};
  endfunction

  task automatic model_reset();
    m_state = 0; m_dwell = 0; m_samples = 0; m_in_run = 0; m_out_run = 0;
  endtask

  // One clock edge of the specified behaviour.
  task automatic model_step(input bit st, input bit vld, input int err);
    int  mag, ns, in_run, out_run;
    bit  counted;
    mag     = (err < 0) ? -err : err;
    counted = vld && (m_state >= 2 && m_state <= 4);
    in_run  = m_in_run;
    out_run = m_out_run;
    if (counted) begin
      if (mag <= 4) begin
        in_run  = (m_in_run < 16) ? m_in_run + 1 : 16;
        out_run = 0;
      end else begin
        out_run = (m_out_run < 4) ? m_out_run + 1 : 4;
        in_run  = 0;
      end
    end
    ns = m_state;
    if (!st) ns = 0;
    else if (m_state == 0) ns = 1;
    else if (m_state == 1) begin
      if (m_dwell == 255) ns = 2;
    end else if (m_state == 2) begin
      if (counted && in_run == 8) ns = 3;
      else if (counted && m_samples + 1 == 1024) ns = 5;
    end else if (m_state == 3) begin
      if (counted && in_run == 16) ns = 4;
      else if (counted && out_run == 4) ns = 2;
    end else if (m_state == 4) begin
      if (counted && out_run == 4) ns = 2;
    end
    if (ns != m_state) begin
      m_state = ns; m_dwell = 0; m_samples = 0; m_in_run = 0; m_out_run = 0;
    end else begin
      m_dwell++;
      if (counted) m_samples++;
      m_in_run  = in_run;
      m_out_run = out_run;
    end
  endtask

  // Drive inputs (caller sits away from the rising edge), clock once, compare with the model.
  task automatic tick(input bit st, input bit vld, input int err);
    start_i       = st;
    error_valid_i = vld;
    error_i       = 8'(err);
    @(posedge fpga_clk_i);
    model_step(st, vld, err);
    #1;
    check_val("outs", 32'(obs_outs()), 32'(exp_outs(m_state)));
  endtask

  // A valid strobe preceded by a short random gap of non-valid cycles.
  task automatic strobe(input int err);
    int gap;
    gap = int'($urandom_range(0, 2));
    for (int g = 0; g < gap; g++) tick(1'b1, 1'b0, int'($urandom_range(0, 255)) - 128);
    tick(1'b1, 1'b1, err);
  endtask

  task automatic do_reset();
    reset_i = 1'b0;
    #1;
    model_reset();
    check_val("rst_async", 32'(obs_outs()), 32'(exp_outs(0)));
    @(posedge fpga_clk_i);
    #1;
    check_val("rst_hold", 32'(obs_outs()), 32'(exp_outs(0)));
    @(negedge fpga_clk_i);
    reset_i = 1'b1;
  endtask

  task automatic run_settle();
    tick(1'b1, 1'b0, 0);
    check_val("settle_enter", 32'(state_o), 32'd1);
    for (int i = 0; i < 255; i++) tick(1'b1, 1'($urandom_range(0, 1)), 0);
    check_val("settle_hold", 32'(state_o), 32'd1);
    check_val("settle_kp", 32'(kp_o), 32'd4);
    tick(1'b1, 1'b0, 0);
    check_val("settle_done", 32'(state_o), 32'd2);
    check_val("acq_enable", 32'(enable_o), 32'd1);
  endtask

  initial begin
    int mode, err;
    bit st, vld;
    model_reset();
    repeat (3) @(posedge fpga_clk_i);
    #1;
    check_val("reset_outs", 32'(obs_outs()), 32'(exp_outs(0)));
    @(negedge fpga_clk_i);
    reset_i = 1'b1;
    tick(1'b0, 1'b0, 0);
    check_val("idle_no_start", 32'(state_o), 32'd0);

    // Settle then acquire, track and lock.
    run_settle();
    for (int i = 0; i < 7; i++) strobe(3);
    check_val("acq_before_8", 32'(state_o), 32'd2);
    strobe(3);
    check_val("track_state", 32'(state_o), 32'd3);
    check_val("track_kp", 32'(kp_o), 32'd2);
    check_val("track_ki", 32'(ki_o), 32'd1);
    for (int i = 0; i < 15; i++) strobe(-4);
    check_val("track_before_16", 32'(state_o), 32'd3);
    strobe(-4);
    check_val("locked_state", 32'(state_o), 32'd4);
    check_val("locked_flag", 32'(locked_o), 32'd1);

    // Unlock needs four consecutive out-of-window samples.
    strobe(10); strobe(10); strobe(10); strobe(0);
    strobe(10); strobe(10); strobe(10);
    check_val("still_locked", 32'(state_o), 32'd4);
    strobe(10);
    check_val("unlock_state", 32'(state_o), 32'd2);
    check_val("unlock_flag", 32'(locked_o), 32'd0);

    // Acquisition timeout with the most negative error.
    for (int i = 0; i < 1023; i++) strobe(-128);
    check_val("acq_before_to", 32'(state_o), 32'd2);
    strobe(-128);
    check_val("fault_state", 32'(state_o), 32'd5);
    check_val("fault_flag", 32'(fault_o), 32'd1);
    check_val("fault_enable", 32'(enable_o), 32'd0);
    tick(1'b1, 1'b1, 0);
    check_val("fault_hold", 32'(state_o), 32'd5);
    tick(1'b0, 1'b0, 0);
    check_val("fault_exit", 32'(state_o), 32'd0);

    // start_i drop beats the lock-qualifying sample.
    run_settle();
    for (int i = 0; i < 8; i++) strobe(0);
    for (int i = 0; i < 15; i++) strobe(1);
    tick(1'b0, 1'b1, 0);
    check_val("drop_beats_lock", 32'(state_o), 32'd0);

    // Reset in the middle of settling.
    tick(1'b1, 1'b0, 0);
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 0);
    do_reset();

    // Random phase: blocks of quiet, mixed and noisy error.
    for (int i = 0; i < 24000; i++) begin
      if ($urandom_range(0, 1999) == 0) do_reset();
      mode = (i / 700) % 3;
      st   = ($urandom_range(0, 399) != 0);
      vld  = 1'($urandom_range(0, 1));
      if (mode == 0)
        err = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 255)) - 128
                                           : int'($urandom_range(0, 8)) - 4;
      else if (mode == 1)
        err = int'($urandom_range(0, 16)) - 8;
      else
        err = int'($urandom_range(0, 255)) - 128;
      tick(st, vld, err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
